n64a_vtiming_meas: RTL and testbench



---
 rtl/n64a_vtiming_meas_pkg.sv | 23 ++
 rtl/n64a_sync_edge.sv | 29 ++
 rtl/n64a_vtiming_meas.sv | 133 +++++++++++++
 tb/tb_n64a_vtiming_meas.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/n64a_vtiming_meas_pkg.sv
// Shared constants and types for the N64 video timing measurement block.
package n64a_vtiming_meas_pkg;

    // Bit positions inside the demuxed sync nibble (all active low)
    localparam int unsigned VSY_IDX  = 3;
    localparam int unsigned CLMP_IDX = 2;
    localparam int unsigned HSY_IDX  = 1;
    localparam int unsigned CSY_IDX  = 0;

    localparam int unsigned NTSC_FIELD_LINES = 263;
    localparam int unsigned PAL_FIELD_LINES  = 313;

    localparam int unsigned DEF_HCNT_W = 11;
    localparam int unsigned DEF_VCNT_W = 10;

    typedef struct packed {
        logic vs_fall;
        logic clmp_fall;
        logic hs_fall;
        logic cs_fall;
    } sync_edges_t;

endpackage

// File: rtl/n64a_sync_edge.sv
// Falling-edge detector for the sync nibble; edges are only seen between two valid slots.
module n64a_sync_edge
    import n64a_vtiming_meas_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [3:0]  sync,
    output sync_edges_t edges
);

    logic [3:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 4'hF;
        end else if (valid) begin
            prev_q <= sync;
        end
    end

    always_comb begin
        edges.vs_fall   = valid & prev_q[VSY_IDX]  & ~sync[VSY_IDX];
        edges.clmp_fall = valid & prev_q[CLMP_IDX] & ~sync[CLMP_IDX];
        edges.hs_fall   = valid & prev_q[HSY_IDX]  & ~sync[HSY_IDX];
        edges.cs_fall   = valid & prev_q[CSY_IDX]  & ~sync[CSY_IDX];
    end

endmodule

// File: rtl/n64a_vtiming_meas.sv
// Measures line length / field length and derives PAL, interlace, field id and lock status.
// Define N64A_VTIMING_HYST_EN to let palmode/interlaced change only while timing is stable.
module n64a_vtiming_meas
    import n64a_vtiming_meas_pkg::*;
#(
    parameter int unsigned HCNT_W        = DEF_HCNT_W,
    parameter int unsigned VCNT_W        = DEF_VCNT_W,
    parameter int unsigned PAL_LINES_MIN = 287,
    parameter int unsigned STABLE_FRAMES = 4
) (
    input  logic              VCLK,
    input  logic              nRST,
    input  logic              vdata_valid_i,
    input  logic [3:0]        vdata_sy_i,
    output logic [HCNT_W-1:0] hcnt_o,
    output logic [VCNT_W-1:0] vcnt_o,
    output logic [HCNT_W-1:0] line_len_o,
    output logic [VCNT_W-1:0] field_lines_o,
    output logic              palmode_o,
    output logic              interlaced_o,
    output logic              field_id_o,
    output logic              stable_o,
    output logic              new_field_o
);

    localparam logic [HCNT_W-1:0] HMAX       = '1;
    localparam logic [VCNT_W-1:0] VMAX       = '1;
    localparam logic [3:0]        STABLE_MAX = 4'(STABLE_FRAMES);

    sync_edges_t edges;

    n64a_sync_edge u_sync_edge (
        .clk   (VCLK),
        .rst_n (nRST),
        .valid (vdata_valid_i),
        .sync  (vdata_sy_i),
        .edges (edges)
    );

    logic unused_edges;
    assign unused_edges = edges.clmp_fall ^ edges.cs_fall;

    logic [HCNT_W-1:0] hcnt_q, line_len_q, hcnt_inc, hcnt_d, line_len_d;
    logic [VCNT_W-1:0] vcnt_q, field_lines_q, vcnt_inc, vcnt_hs, vcnt_d;
    logic [3:0]        stab_cnt_q, stab_cnt_d;
    logic              palmode_q, interlaced_q, field_id_q, stable_q, new_field_q;
    logic              first_q, prev_il_q;
    logic              fid_cand, pal_cand, il_cand, near, match, timeout;

    always_comb begin
        hcnt_inc   = (hcnt_q == HMAX) ? HMAX : hcnt_q + 1'b1;
        vcnt_inc   = (vcnt_q == VMAX) ? VMAX : vcnt_q + 1'b1;
        hcnt_d     = edges.hs_fall ? '0 : hcnt_inc;
        line_len_d = edges.hs_fall ? hcnt_inc : line_len_q;
        // A coincident hsync is applied before the field boundary looks at vcnt
        vcnt_hs    = edges.hs_fall ? vcnt_inc : vcnt_q;
        vcnt_d     = edges.vs_fall ? '0 : vcnt_hs;

        fid_cand = (hcnt_q >= (line_len_q >> 1));
        pal_cand = (vcnt_hs > VCNT_W'(PAL_LINES_MIN));
        il_cand  = (fid_cand != field_id_q);

        near = ({1'b0, vcnt_hs} == {1'b0, field_lines_q})
             | ({1'b0, vcnt_hs} == {1'b0, field_lines_q} + 1'b1)
             | ({1'b0, vcnt_hs} + 1'b1 == {1'b0, field_lines_q});
        match = ~first_q & near & (il_cand == prev_il_q);

        stab_cnt_d = 4'd0;
        if (match) begin
            stab_cnt_d = (stab_cnt_q == STABLE_MAX) ? STABLE_MAX : stab_cnt_q + 4'd1;
        end

        timeout = (hcnt_d == HMAX) | (vcnt_d == VMAX);
    end

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            line_len_q    <= '0;
            field_lines_q <= '0;
            palmode_q     <= 1'b0;
            interlaced_q  <= 1'b0;
            field_id_q    <= 1'b0;
            stable_q      <= 1'b0;
            new_field_q   <= 1'b0;
            stab_cnt_q    <= 4'd0;
            first_q       <= 1'b1;
            prev_il_q     <= 1'b0;
        end else begin
            new_field_q <= 1'b0;
            if (vdata_valid_i) begin
                hcnt_q     <= hcnt_d;
                vcnt_q     <= vcnt_d;
                line_len_q <= line_len_d;
                if (edges.vs_fall) begin
                    field_lines_q <= vcnt_hs;
                    field_id_q    <= fid_cand;
                    prev_il_q     <= il_cand;
                    first_q       <= 1'b0;
                    new_field_q   <= 1'b1;
                    stab_cnt_q    <= stab_cnt_d;
                    stable_q      <= (stab_cnt_d == STABLE_MAX);
`ifdef N64A_VTIMING_HYST_EN
                    if ((stab_cnt_d == STABLE_MAX) && !timeout) begin
                        palmode_q    <= pal_cand;
                        interlaced_q <= il_cand;
                    end
`else
                    palmode_q    <= pal_cand;
                    interlaced_q <= il_cand;
`endif
                end
                // Saturated counters mean sync was lost: drop lock, keep mode flags
                if (timeout) begin
                    stab_cnt_q <= 4'd0;
                    stable_q   <= 1'b0;
                end
            end
        end
    end

    assign hcnt_o        = hcnt_q;
    assign vcnt_o        = vcnt_q;
    assign line_len_o    = line_len_q;
    assign field_lines_o = field_lines_q;
    assign palmode_o     = palmode_q;
    assign interlaced_o  = interlaced_q;
    assign field_id_o    = field_id_q;
    assign stable_o      = stable_q;
    assign new_field_o   = new_field_q;

endmodule

// File: tb/tb_n64a_vtiming_meas.sv
// Directed + randomized bench for n64a_vtiming_meas against a slot-level reference model.
module tb_n64a_vtiming_meas;

    localparam int HMAX    = 2047;
    localparam int VMAX    = 1023;
    localparam int PAL_MIN = 287;
    localparam int STAB    = 4;
    localparam int LLEN    = 6;

    logic        VCLK = 1'b0;
    logic        nRST;
    logic        vdata_valid_i;
    logic [3:0]  vdata_sy_i;
    logic [10:0] hcnt_o;
    logic [9:0]  vcnt_o;
    logic [10:0] line_len_o;
    logic [9:0]  field_lines_o;
    logic        palmode_o, interlaced_o, field_id_o, stable_o, new_field_o;

    n64a_vtiming_meas dut (
        .VCLK          (VCLK),
        .nRST          (nRST),
        .vdata_valid_i (vdata_valid_i),
        .vdata_sy_i    (vdata_sy_i),
        .hcnt_o        (hcnt_o),
        .vcnt_o        (vcnt_o),
        .line_len_o    (line_len_o),
        .field_lines_o (field_lines_o),
        .palmode_o     (palmode_o),
        .interlaced_o  (interlaced_o),
        .field_id_o    (field_id_o),
        .stable_o      (stable_o),
        .new_field_o   (new_field_o)
    );

    always #5 VCLK = ~VCLK;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int         m_h, m_v, m_ll, m_fl, m_cnt;
    bit         m_pal, m_il, m_fid, m_stable, m_first, m_prev_il, m_nf;
    logic [3:0] m_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_v = 0; m_ll = 0; m_fl = 0; m_cnt = 0;
        m_pal = 0; m_il = 0; m_fid = 0; m_stable = 0; m_nf = 0;
        m_first = 1; m_prev_il = 0; m_prev = 4'hF;
    endtask

    task automatic model_step(input logic [3:0] nib);
        bit hs, vs, fidc, palc, ilc, match;
        int old_h, old_ll, lines, diff;
        hs = m_prev[1] && !nib[1];
        vs = m_prev[3] && !nib[3];
        m_prev = nib;
        old_h = m_h;
        old_ll = m_ll;
        m_nf = 0;
        if (hs) begin
            m_ll = (m_h + 1 > HMAX) ? HMAX : m_h + 1;
            m_h = 0;
            m_v = (m_v + 1 > VMAX) ? VMAX : m_v + 1;
        end else begin
            m_h = (m_h + 1 > HMAX) ? HMAX : m_h + 1;
        end
        if (vs) begin
            lines = m_v;
            fidc = (old_h >= old_ll / 2);
            palc = (lines > PAL_MIN);
            ilc = (fidc != m_fid);
            diff = lines - m_fl;
            match = !m_first && (diff >= -1) && (diff <= 1) && (ilc == m_prev_il);
            if (match) m_cnt = (m_cnt < STAB) ? m_cnt + 1 : STAB;
            else m_cnt = 0;
            m_stable = (m_cnt == STAB);
            m_first = 0;
            m_prev_il = ilc;
            m_fl = lines;
            m_v = 0;
            m_fid = fidc;
            m_pal = palc;
            m_il = ilc;
            m_nf = 1;
        end
        if (m_h == HMAX || m_v == VMAX) begin
            m_cnt = 0;
            m_stable = 0;
        end
    endtask

    task automatic check_all();
        check("hcnt", hcnt_o, m_h);
        check("vcnt", vcnt_o, m_v);
        check("line_len", line_len_o, m_ll);
        check("field_lines", field_lines_o, m_fl);
        check("palmode", palmode_o, m_pal);
        check("interlaced", interlaced_o, m_il);
        check("field_id", field_id_o, m_fid);
        check("stable", stable_o, m_stable);
        check("new_field", new_field_o, m_nf);
    endtask

    function automatic logic [3:0] mk(input bit vs, input bit hs);
        return {vs, 1'($urandom), hs, 1'($urandom)};
    endfunction

    // One valid slot followed by gap invalid cycles carrying garbage nibbles
    task automatic slot(input logic [3:0] nib, input int gap);
        vdata_sy_i = nib;
        vdata_valid_i = 1'b1;
        @(negedge VCLK);
        vdata_valid_i = 1'b0;
        model_step(nib);
        check("hcnt", hcnt_o, m_h);
        check("vcnt", vcnt_o, m_v);
        check("new_field", new_field_o, m_nf);
        if (m_nf) check_all();
        for (int g = 0; g < gap; g++) begin
            vdata_sy_i = 4'($urandom);
            @(negedge VCLK);
            m_nf = 0;
            check("hold_hcnt", hcnt_o, m_h);
            check("hold_vcnt", vcnt_o, m_v);
            check("nf_clear", new_field_o, 0);
        end
    endtask

    // Field of nlines lines; vsync falls at line start or mid-line, low for one line
    task automatic run_field(input int nlines, input bit mid, input int skip);
        int vsidx, s;
        bit hs, vs;
        vsidx = mid ? LLEN / 2 : 0;
        for (int idx = skip; idx < nlines * LLEN; idx++) begin
            s = idx % LLEN;
            hs = (s != 0);
            vs = !(idx >= vsidx && idx < vsidx + LLEN);
            slot(mk(vs, hs), 0);
        end
    endtask

    initial begin
        nRST = 1'b0;
        vdata_valid_i = 1'b0;
        vdata_sy_i = 4'hF;
        model_reset();
        repeat (2) @(negedge VCLK);
        check("rst_hcnt", hcnt_o, 0);
        check("rst_line_len", line_len_o, 0);
        check("rst_stable", stable_o, 0);
        check_all();
        nRST = 1'b1;
        @(negedge VCLK);

        // NTSC progressive, vsync aligned with hsync
        for (int f = 0; f < 7; f++) run_field(263, 1'b0, 0);
        check("ntsc_line_len", line_len_o, LLEN);
        check("ntsc_field_lines", field_lines_o, 263);
        check("ntsc_pal", palmode_o, 0);
        check("ntsc_il", interlaced_o, 0);
        check("ntsc_stable", stable_o, 1);

        // Simultaneous hsync/vsync edge at vcnt=262
        check("pre_vcnt", vcnt_o, 262);
        slot(mk(1'b0, 1'b0), 0);
        check("sim_field_lines", field_lines_o, 263);
        check("sim_vcnt", vcnt_o, 0);
        check("sim_hcnt", hcnt_o, 0);
        check("sim_nf", new_field_o, 1);
        slot(mk(1'b0, 1'b1), 0);
        check("sim_nf_clr", new_field_o, 0);
        run_field(250, 1'b0, 2);

        // Short field breaks lock, then four matches restore it
        run_field(263, 1'b0, 0);
        check("mm_field_lines", field_lines_o, 250);
        check("mm_stable", stable_o, 0);
        for (int f = 0; f < 5; f++) run_field(263, 1'b0, 0);
        check("mm_restable", stable_o, 1);
        check("mm_pal", palmode_o, 0);

        // Async reset mid-line while locked
        slot(mk(1'b0, 1'b0), 0);
        slot(mk(1'b0, 1'b1), 0);
        slot(mk(1'b0, 1'b1), 0);
        check("pre_rst_stable", stable_o, 1);
        #2 nRST = 1'b0;
        #1;
        model_reset();
        check("arst_hcnt", hcnt_o, 0);
        check("arst_stable", stable_o, 0);
        check("arst_field_lines", field_lines_o, 0);
        check_all();
        @(negedge VCLK);
        @(negedge VCLK);
        nRST = 1'b1;
        for (int i = 0; i < 20; i++) slot(mk(1'b1, 1'b1), 3);
        check("gap_hcnt", hcnt_o, 20);

        // PAL interlaced: 313 aligned / 312 mid-line fields
        for (int f = 0; f < 8; f++) run_field((f % 2) ? 312 : 313, f % 2, 0);
        check("pal_pal", palmode_o, 1);
        check("pal_il", interlaced_o, 1);
        check("pal_stable", stable_o, 1);

        // Sync loss: hsync stuck high
        for (int i = 0; i < 2048; i++) slot(mk(1'b1, 1'b1), 0);
        check("loss_hcnt", hcnt_o, HMAX);
        check("loss_stable", stable_o, 0);
        check("loss_pal", palmode_o, 1);
        check("loss_il", interlaced_o, 1);

        // Random nibbles with random valid gaps
        for (int i = 0; i < 1500; i++) begin
            slot(mk($urandom_range(0, 63) != 0, $urandom_range(0, 7) != 0),
                 int'($urandom_range(0, 2)));
            check_all();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
